// File: rtl/block_stream_gen.sv
// Word-command to ASCII byte serializer ("begin ", "end ", " ") with nesting-depth tracking.
// Optional BSG_UPPER_EN adds an 'upper' input selecting uppercase keywords per word.
module block_stream_gen #(
    parameter int DEPTH_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    input  logic [1:0]         cmd,
    output logic               cmd_ready,
    output logic [7:0]         out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DEPTH_W-1:0] depth,
    output logic               balanced,
    output logic               err
`ifdef BSG_UPPER_EN
    ,
    input  logic               upper
`endif
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    localparam logic [1:0]         CMD_BEGIN = 2'b00;
    localparam logic [1:0]         CMD_END   = 2'b01;
    localparam logic [1:0]         CMD_SPACE = 2'b10;
    localparam logic [DEPTH_W-1:0] DEPTH_MAX = {DEPTH_W{1'b1}};
    localparam logic [DEPTH_W-1:0] DEPTH_0   = {DEPTH_W{1'b0}};
    localparam logic [DEPTH_W-1:0] DEPTH_1   = {{(DEPTH_W-1){1'b0}}, 1'b1};

    // Index of the trailing space for each word.
    function automatic logic [2:0] word_last(input logic [1:0] w);
        logic [2:0] l;
        case (w)
            CMD_BEGIN: l = 3'd5;
            CMD_END:   l = 3'd3;
            default:   l = 3'd0;
        endcase
        return l;
    endfunction

    function automatic logic [7:0] word_char(input logic [1:0] w, input logic up, input logic [2:0] i);
        logic [7:0] c;
        c = 8'h20;
        case (w)
            CMD_BEGIN: begin
                case (i)
                    3'd0:    c = 8'h62;
                    3'd1:    c = 8'h65;
                    3'd2:    c = 8'h67;
                    3'd3:    c = 8'h69;
                    3'd4:    c = 8'h6E;
                    default: c = 8'h20;
                endcase
            end
            CMD_END: begin
                case (i)
                    3'd0:    c = 8'h65;
                    3'd1:    c = 8'h6E;
                    3'd2:    c = 8'h64;
                    default: c = 8'h20;
                endcase
            end
            default: c = 8'h20;
        endcase
        return (up && (c != 8'h20)) ? (c - 8'h20) : c;
    endfunction

    state_t             state_r,  state_nxt_s;
    logic [2:0]         idx_r,    idx_nxt_s;
    logic [1:0]         word_r,   word_nxt_s;
    logic               upper_r,  upper_nxt_s;
    logic [DEPTH_W-1:0] depth_r,  depth_nxt_s;
    logic               err_r,    err_nxt_s;
    logic               cmd_ready_r, cmd_ready_nxt_s;
    logic               out_valid_r, out_valid_nxt_s;
    logic [7:0]         out_data_r,  out_data_nxt_s;
    logic               upper_s;
    logic               legal_s;

`ifdef BSG_UPPER_EN
    assign upper_s = upper;
`else
    assign upper_s = 1'b0;
`endif

    // Command legality against the current registered depth.
    always_comb begin
        legal_s = 1'b0;
        case (cmd)
            CMD_BEGIN: legal_s = (depth_r != DEPTH_MAX);
            CMD_END:   legal_s = (depth_r != DEPTH_0);
            CMD_SPACE: legal_s = 1'b1;
            default:   legal_s = 1'b0;
        endcase
    end

    // State and context registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            idx_r   <= 3'd0;
            word_r  <= CMD_SPACE;
            upper_r <= 1'b0;
            depth_r <= DEPTH_0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            idx_r   <= idx_nxt_s;
            word_r  <= word_nxt_s;
            upper_r <= upper_nxt_s;
            depth_r <= depth_nxt_s;
            err_r   <= err_nxt_s;
        end
    end

    // Next-state logic: depth moves at acceptance, not at word completion.
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        word_nxt_s  = word_r;
        upper_nxt_s = upper_r;
        depth_nxt_s = depth_r;
        err_nxt_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (legal_s) begin
                        state_nxt_s = ST_EMIT;
                        idx_nxt_s   = 3'd0;
                        word_nxt_s  = cmd;
                        upper_nxt_s = upper_s;
                        case (cmd)
                            CMD_BEGIN: depth_nxt_s = depth_r + DEPTH_1;
                            CMD_END:   depth_nxt_s = depth_r - DEPTH_1;
                            default:   depth_nxt_s = depth_r;
                        endcase
                    end else begin
                        err_nxt_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    if (idx_r == word_last(word_r)) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        idx_nxt_s = idx_r + 3'd1;
                    end
                end else begin
                    state_nxt_s = ST_EMIT;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output decode from the next state so the handshake outputs come straight from flops.
    always_comb begin
        cmd_ready_nxt_s = (state_nxt_s == ST_IDLE);
        out_valid_nxt_s = (state_nxt_s == ST_EMIT);
        if (state_nxt_s == ST_EMIT) begin
            out_data_nxt_s = word_char(word_nxt_s, upper_nxt_s, idx_nxt_s);
        end else begin
            out_data_nxt_s = 8'h00;
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cmd_ready_r <= 1'b1;
            out_valid_r <= 1'b0;
            out_data_r  <= 8'h00;
        end else begin
            cmd_ready_r <= cmd_ready_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            out_data_r  <= out_data_nxt_s;
        end
    end

    assign cmd_ready = cmd_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign depth     = depth_r;
    assign balanced  = (depth_r == DEPTH_0);
    assign err       = err_r;

endmodule

// File: tb/tb_block_stream_gen.sv
// Bench for block_stream_gen (DEPTH_W=2): directed steps plus random commands against a byte-queue model.
module tb_block_stream_gen;

    localparam int DW   = 2;
    localparam int MAXD = 3;
`ifdef BSG_UPPER_EN
    localparam bit UPPER_BUILD = 1'b1;
`else
    localparam bit UPPER_BUILD = 1'b0;
`endif

    logic          clk       = 1'b0;
    logic          reset     = 1'b0;
    logic          cmd_valid = 1'b0;
    logic [1:0]    cmd       = 2'b00;
    logic          cmd_ready;
    logic [7:0]    out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] depth;
    logic          balanced;
    logic          err;
`ifdef BSG_UPPER_EN
    logic          upper     = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    int m_depth = 0;
    byte unsigned exp_q[$];
    byte unsigned got_q[$];

    block_stream_gen #(.DEPTH_W(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd       (cmd),
        .cmd_ready (cmd_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .depth     (depth),
        .balanced  (balanced),
        .err       (err)
`ifdef BSG_UPPER_EN
        ,
        .upper     (upper)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit legal_cmd(input logic [1:0] c);
        if (c == 2'd0) return m_depth < MAXD;
        if (c == 2'd1) return m_depth > 0;
        return c == 2'd2;
    endfunction

    task automatic do_reset();
        reset = 1'b0; cmd_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        exp_q.delete();
        m_depth = 0;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 8'h00);
        check("rst_depth", depth, 0);
        check("rst_balanced", balanced, 1);
        check("rst_err", err, 0);
    endtask

    // Present one command in IDLE and update the model.
    task automatic issue(input logic [1:0] c, input bit up);
        bit ok;
        bit up_eff;
        string s;
        byte unsigned b;
        ok = legal_cmd(c);
        up_eff = up & UPPER_BUILD;
        check("idle_cmd_ready", cmd_ready, 1);
        if (ok) begin
            s = (c == 2'd0) ? "begin " : (c == 2'd1) ? "end " : " ";
            for (int i = 0; i < s.len(); i++) begin
                b = s[i];
                if (up_eff && b != 8'h20) b = b - 8'd32;
                exp_q.push_back(b);
            end
            m_depth += (c == 2'd0) ? 1 : (c == 2'd1) ? -1 : 0;
        end
        cmd_valid = 1'b1;
        cmd = c;
`ifdef BSG_UPPER_EN
        upper = up;
`endif
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("cmd_err", err, !ok);
        check("cmd_depth", depth, m_depth);
        check("cmd_balanced", balanced, m_depth == 0);
        check("cmd_out_valid", out_valid, ok);
        if (!ok) begin
            @(posedge clk); #1;
            check("err_one_cycle", err, 0);
            check("refused_no_out", out_valid, 0);
            check("refused_depth", depth, m_depth);
        end
    endtask

    // Drain expected bytes; mode 0 always ready, 1 alternating 1,0,.., 2 random.
    task automatic drain(input int mode, input bit junk, output int cycles);
        bit rdy;
        bit phase;
        int guard;
        byte unsigned seen;
        phase = 1'b1; guard = 0; cycles = 0;
        while (exp_q.size() > 0) begin
            check("emit_valid", out_valid, 1);
            check("emit_data", out_data, exp_q[0]);
            check("emit_cmd_ready", cmd_ready, 0);
            seen = out_data;
            rdy = (mode == 0) ? 1'b1 : (mode == 1) ? phase : 1'($urandom_range(0, 1));
            phase = !phase;
            out_ready = rdy;
            if (junk) begin
                cmd_valid = 1'b1;
                cmd = 2'($urandom_range(0, 3));
            end
            @(posedge clk); #1;
            cycles++;
            if (rdy) begin
                void'(exp_q.pop_front());
                got_q.push_back(seen);
            end
            guard++;
            if (guard > 100) begin
                check("drain_timeout", guard, 0);
                exp_q.delete();
            end
        end
        cmd_valid = 1'b0;
        out_ready = 1'b0;
        check("word_done_valid", out_valid, 0);
        check("word_done_ready", cmd_ready, 1);
        check("word_done_depth", depth, m_depth);
    endtask

    initial begin
        int cyc;
        int n;
        string ref_s;
        byte unsigned rb;
        logic [1:0] rc;

        // 1: reset
        do_reset();

        // 2: BEGIN at full throughput
        got_q.delete();
        issue(2'd0, 1'b0);
        check("begin_balanced", balanced, 0);
        n = exp_q.size();
        drain(0, 1'b0, cyc);
        check("begin_cycles", cyc, n);
        check("begin_len", got_q.size(), 6);
        issue(2'd1, 1'b0);
        drain(0, 1'b0, cyc);

        // 3: END at depth 0 refused
        issue(2'd1, 1'b0);
        check("end_at_zero_depth", depth, 0);
        issue(2'd3, 1'b0);

        // 4: BEGIN END with stalls, compare the stream
        got_q.delete();
        issue(2'd0, 1'b0);
        drain(1, 1'b0, cyc);
        issue(2'd1, 1'b0);
        drain(1, 1'b0, cyc);
        ref_s = "begin end ";
        check("stream_len", got_q.size(), 10);
        for (int i = 0; i < 10; i++) begin
            rb = ref_s[i];
            check("stream_byte", (i < got_q.size()) ? got_q[i] : 8'hFF, rb);
        end
        check("stream_balanced", balanced, 1);

        // 5: saturation at depth 3
        for (int i = 0; i < 4; i++) begin
            issue(2'd0, 1'b0);
            drain(2, 1'b0, cyc);
        end
        check("sat_depth", depth, 3);
        for (int i = 0; i < 3; i++) begin
            issue(2'd1, 1'b0);
            drain(2, 1'b0, cyc);
        end
        check("unwound_balanced", balanced, 1);

        // 6: reset during the third byte of "begin "
        issue(2'd0, 1'b0);
        out_ready = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            void'(exp_q.pop_front());
        end
        out_ready = 1'b0;
        check("third_byte", out_data, 8'h67);
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        exp_q.delete();
        m_depth = 0;
        check("midrst_valid", out_valid, 0);
        check("midrst_depth", depth, 0);
        check("midrst_ready", cmd_ready, 1);
        got_q.delete();
        issue(2'd2, 1'b0);
        drain(0, 1'b0, cyc);
        check("space_cycles", cyc, 1);
        check("space_byte", (got_q.size() > 0) ? got_q[0] : 8'hFF, 8'h20);

        // Random commands, stalls, case select and commands held during emission
        for (int k = 0; k < 40; k++) begin
            rc = 2'($urandom_range(0, 3));
            issue(rc, 1'($urandom_range(0, 1)));
            drain(2, 1'($urandom_range(0, 1)), cyc);
        end
        check("final_depth", depth, m_depth);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
